seg7_scan_driver: RTL

- Downstream display stage of the stopwatch. Takes the MM:SS digits from the timekeeping core and time-multiplexes them onto the 4-digit common-anode 7-segment display.
- Drives active-low `seg` and `an`, which the top wrapper routes to `uo_out[6:0]` and `uio_out[3:0]`.
- Per-digit ghost-blanking dead time, a coherent per-scan digit snapshot, per-digit blink for set mode, and optional leading-zero blanking.

---
 rtl/seg7_scan_driver_if.sv | 32 +++
 rtl/seg7_scan_driver.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// Purpose: display-side bundle between the stopwatch core and the 7-segment scan driver.
// Signals:
//   en                      display enable (low = hold counters, display dark)
//   sec_ones .. min_tens    BCD digits, digit 0 (rightmost) .. digit 3 (leftmost)
//   blink_mask              bit i set: digit i blinks
//   blank_lead              blank digit 3 when its snapshot value is zero
//   seg                     active-low segments, seg[0]=a .. seg[6]=g
//   an                      active-low anodes, an[i] selects digit i
//   scan_wrap               one-cycle pulse at the end of each full 4-digit scan
// Modports: master = digit source / display consumer, slave = scan driver.
interface seg7_scan_driver_if;
    logic       en;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [3:0] blink_mask;
    logic       blank_lead;
    logic [6:0] seg;
    logic [3:0] an;
    logic       scan_wrap;

    modport master (
        output en, sec_ones, sec_tens, min_ones, min_tens, blink_mask, blank_lead,
        input  seg, an, scan_wrap
    );

    modport slave (
        input  en, sec_ones, sec_tens, min_ones, min_tens, blink_mask, blank_lead,
        output seg, an, scan_wrap
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexes the MM:SS digits onto a 4-digit common-anode 7-segment
// display, with per-slot ghost-blanking dead time, a coherent per-scan snapshot,
// per-digit blink and optional leading-zero blanking.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   seg7_scan_driver_if.slave (digit inputs in, seg/an/scan_wrap out, all registered)
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_SCANS  = 125
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned SLOT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned BLINK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SCANS - 1);

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [1:0]         dig_q, dig_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic [3:0][3:0]    snap_q, snap_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               wrap_q, wrap_d;
    logic               capture;
    logic               suppress;

    // Active-low gfedcba decode; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next-state and output logic.
    always_comb begin
        slot_d      = slot_q;
        dig_d       = dig_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        snap_d      = snap_q;
        wrap_d      = 1'b0;
        an_d        = 4'b1111;
        seg_d       = 7'b1111111;
        capture     = bus.en && (slot_q == '0) && (dig_q == 2'd0);

        // The digit being captured this cycle is also the one displayed, so the view uses snap_d.
        if (capture) begin
            snap_d = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
        end

        suppress = (blink_ph_q && bus.blink_mask[dig_q]) ||
                   ((dig_q == 2'd3) && bus.blank_lead && (snap_d[3] == 4'd0));

        if (bus.en) begin
            if (slot_q == SLOT_LAST) begin
                slot_d = '0;
                dig_d  = dig_q + 2'd1;
                // Blink counter advances with the scan_wrap event so the phase flips on a scan boundary.
                if (dig_q == 2'd3) begin
                    wrap_d = 1'b1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_ph_d  = ~blink_ph_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end

            if ((slot_q >= SLOT_BLANK) && !suppress) begin
                an_d  = ~(4'b0001 << dig_q);
                seg_d = seg_decode(snap_d[dig_q]);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            dig_q       <= 2'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            snap_q      <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            wrap_q      <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.scan_wrap = wrap_q;

endmodule
